// File: rtl/param_step_counter.sv
// Signed up/down step counter with skip-value step doubling, bound hold or wrap,
// load with clamping, and a saturating wrap counter. All outputs are registered.
module param_step_counter #(
  parameter int WIDTH         = 10,
  parameter int INIT          = -50,
  parameter int MIN_VAL       = -230,
  parameter int MAX_VAL       = 235,
  parameter int UP_STEP       = 5,
  parameter int DOWN_STEP     = 9,
  parameter int UP_SKIP_VAL   = -16,
  parameter int DOWN_SKIP_VAL = -2,
  parameter int WRAP          = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_val,
  output logic signed [WIDTH-1:0] cnt,
  output logic                    at_limit,
  output logic                    skipped,
  output logic                    wrapped,
  output logic [7:0]              wrap_cnt
);

  // Two guard bits keep every step and bound comparison free of overflow.
  localparam int XW     = WIDTH + 2;
  localparam int REP_LO = -(1 <<< (WIDTH - 1));
  localparam int REP_HI = (1 << (WIDTH - 1)) - 1;

  localparam logic signed [XW-1:0] MIN_X    = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X    = XW'(MAX_VAL);
  localparam logic signed [XW-1:0] UP_X     = XW'(UP_STEP);
  localparam logic signed [XW-1:0] UP2_X    = XW'(2 * UP_STEP);
  localparam logic signed [XW-1:0] DN_X     = XW'(DOWN_STEP);
  localparam logic signed [XW-1:0] DN2_X    = XW'(2 * DOWN_STEP);
  localparam logic signed [XW-1:0] UPSKIP_X = XW'(UP_SKIP_VAL);
  localparam logic signed [XW-1:0] DNSKIP_X = XW'(DOWN_SKIP_VAL);

  if (INIT < MIN_VAL || INIT > MAX_VAL) begin : g_bad_init
    $error("INIT must lie within [MIN_VAL, MAX_VAL]");
  end
  if (UP_STEP <= 0 || DOWN_STEP <= 0) begin : g_bad_step
    $error("UP_STEP and DOWN_STEP must be positive");
  end
  if (2 * UP_STEP >= MAX_VAL - MIN_VAL || 2 * DOWN_STEP >= MAX_VAL - MIN_VAL) begin : g_bad_span
    $error("doubled step must be smaller than MAX_VAL - MIN_VAL");
  end
  if (MIN_VAL < REP_LO || MAX_VAL > REP_HI || UP_SKIP_VAL < REP_LO || UP_SKIP_VAL > REP_HI ||
      DOWN_SKIP_VAL < REP_LO || DOWN_SKIP_VAL > REP_HI || 2 * UP_STEP > REP_HI ||
      2 * DOWN_STEP > REP_HI) begin : g_bad_range
    $error("parameter values must be representable in WIDTH signed bits");
  end

  function automatic logic signed [WIDTH-1:0] clamp_val(input logic signed [XW-1:0] v);
    if (v < MIN_X)      return MIN_X[WIDTH-1:0];
    else if (v > MAX_X) return MAX_X[WIDTH-1:0];
    else                return v[WIDTH-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [XW-1:0]    cnt_x;
  logic signed [XW-1:0]    step_x;
  logic signed [XW-1:0]    nxt_x;
  logic                    dbl;
  logic                    in_range;
  logic signed [WIDTH-1:0] cnt_d;
  logic                    at_limit_d;
  logic                    skipped_d;
  logic                    wrapped_d;
  logic [7:0]              wrap_cnt_d;

  always_comb begin
    cnt_x = XW'(cnt);
    if (mode) begin
      dbl    = (cnt_x == UPSKIP_X);
      step_x = dbl ? UP2_X : UP_X;
      nxt_x  = cnt_x + step_x;
    end else begin
      dbl    = (cnt_x == DNSKIP_X);
      step_x = dbl ? DN2_X : DN_X;
      nxt_x  = cnt_x - step_x;
    end
    in_range = (nxt_x >= MIN_X) && (nxt_x <= MAX_X);
  end

  // Flags default to 0 so each one describes only this cycle's operation.
  always_comb begin
    cnt_d      = cnt;
    at_limit_d = 1'b0;
    skipped_d  = 1'b0;
    wrapped_d  = 1'b0;
    wrap_cnt_d = wrap_cnt;
    if (load) begin
      cnt_d = clamp_val(XW'(load_val));
    end else if (en) begin
      if (in_range) begin
        cnt_d     = nxt_x[WIDTH-1:0];
        skipped_d = dbl;
      end else if (WRAP != 0) begin
        cnt_d      = mode ? MIN_X[WIDTH-1:0] : MAX_X[WIDTH-1:0];
        wrapped_d  = 1'b1;
        wrap_cnt_d = sat_inc8(wrap_cnt);
      end else begin
        at_limit_d = 1'b1;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= WIDTH'(INIT);
      at_limit <= 1'b0;
      skipped  <= 1'b0;
      wrapped  <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      cnt      <= cnt_d;
      at_limit <= at_limit_d;
      skipped  <= skipped_d;
      wrapped  <= wrapped_d;
      wrap_cnt <= wrap_cnt_d;
    end
  end

endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: a hold instance and a wrap instance share stimulus and
// are compared every cycle against an integer model, with literal spot checks on top.
module tb_param_step_counter;
  localparam int W      = 10;
  localparam int LO     = -230;
  localparam int HI     = 235;
  localparam int INITV  = -50;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic load = 1'b0;
  logic signed [W-1:0] load_val = '0;

  logic signed [W-1:0] cnt [2];
  logic                at_limit [2];
  logic                skipped [2];
  logic                wrapped [2];
  logic [7:0]          wrap_cnt [2];

  int n_checks = 0;
  int n_err = 0;

  int m_cnt [2] = '{INITV, INITV};
  int m_al  [2] = '{0, 0};
  int m_sk  [2] = '{0, 0};
  int m_wr  [2] = '{0, 0};
  int m_wc  [2] = '{0, 0};

  param_step_counter #(.WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .cnt(cnt[0]), .at_limit(at_limit[0]), .skipped(skipped[0]), .wrapped(wrapped[0]),
    .wrap_cnt(wrap_cnt[0])
  );

  param_step_counter #(.WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .cnt(cnt[1]), .at_limit(at_limit[1]), .skipped(skipped[1]), .wrapped(wrapped[1]),
    .wrap_cnt(wrap_cnt[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = INITV;
      m_al[i] = 0;
      m_sk[i] = 0;
      m_wr[i] = 0;
      m_wc[i] = 0;
    end
  endtask

  // Instance 1 wraps, instance 0 holds at the bound.
  task automatic model_step(input int i);
    int lv;
    int nxt;
    int dbl;
    lv = int'(load_val);
    m_al[i] = 0;
    m_sk[i] = 0;
    m_wr[i] = 0;
    if (load) begin
      m_cnt[i] = (lv < LO) ? LO : (lv > HI) ? HI : lv;
    end else if (en) begin
      if (mode) begin
        dbl = (m_cnt[i] == -16) ? 1 : 0;
        nxt = m_cnt[i] + (dbl == 1 ? 10 : 5);
      end else begin
        dbl = (m_cnt[i] == -2) ? 1 : 0;
        nxt = m_cnt[i] - (dbl == 1 ? 18 : 9);
      end
      if (nxt >= LO && nxt <= HI) begin
        m_cnt[i] = nxt;
        m_sk[i] = dbl;
      end else if (i == 1) begin
        m_cnt[i] = mode ? LO : HI;
        m_wr[i] = 1;
        if (m_wc[i] < 255) m_wc[i]++;
      end else begin
        m_al[i] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model dut%0d.cnt", i), cnt[i], m_cnt[i]);
        check($sformatf("model dut%0d.at_limit", i), at_limit[i], m_al[i]);
        check($sformatf("model dut%0d.skipped", i), skipped[i], m_sk[i]);
        check($sformatf("model dut%0d.wrapped", i), wrapped[i], m_wr[i]);
        check($sformatf("model dut%0d.wrap_cnt", i), wrap_cnt[i], m_wc[i]);
      end
    end
  end

  task automatic drive(input bit l, input int lv, input bit e, input bit m);
    load = l;
    load_val = lv[W-1:0];
    en = e;
    mode = m;
    @(posedge clk);
    #3;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s dut%0d.cnt", tag, i), cnt[i], INITV);
      check($sformatf("%s dut%0d.at_limit", tag, i), at_limit[i], 0);
      check($sformatf("%s dut%0d.skipped", tag, i), skipped[i], 0);
      check($sformatf("%s dut%0d.wrapped", tag, i), wrapped[i], 0);
      check($sformatf("%s dut%0d.wrap_cnt", tag, i), wrap_cnt[i], 0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    drive(1, -16, 0, 0);
    check("load -16", cnt[0], -16);
    drive(0, 0, 1, 1);
    check("up skip cnt", cnt[0], -6);
    check("up skip flag", skipped[0], 1);
    drive(0, 0, 1, 1);
    check("up normal cnt", cnt[0], -1);
    check("up normal flag", skipped[0], 0);
    drive(0, 0, 0, 1);
    check("hold cnt", cnt[0], -1);

    drive(1, -2, 0, 0);
    drive(0, 0, 1, 0);
    check("down skip cnt", cnt[0], -20);
    check("down skip flag", skipped[0], 1);

    drive(1, 233, 0, 0);
    drive(0, 0, 1, 1);
    check("hold top cnt", cnt[0], 233);
    check("hold top at_limit", at_limit[0], 1);
    check("wrap top cnt", cnt[1], -230);
    check("wrap top wrapped", wrapped[1], 1);
    check("wrap top wrap_cnt", wrap_cnt[1], 1);
    drive(0, 0, 1, 1);
    check("hold top again cnt", cnt[0], 233);
    check("hold top again at_limit", at_limit[0], 1);

    drive(1, -225, 0, 0);
    drive(0, 0, 1, 0);
    check("hold bottom cnt", cnt[0], -225);
    check("hold bottom at_limit", at_limit[0], 1);
    check("wrap bottom cnt", cnt[1], 235);
    check("wrap bottom wrap_cnt", wrap_cnt[1], 2);
    drive(0, 0, 1, 0);
    check("hold bottom again cnt", cnt[0], -225);

    // Alternating direction at the top bound wraps the wrap instance on every edge.
    drive(1, 235, 0, 0);
    for (int k = 0; k < 300; k++) drive(0, 0, 1, (k % 2) == 0);
    check("wrap_cnt saturates", wrap_cnt[1], 255);
    check("hold instance wrap_cnt", wrap_cnt[0], 0);

    drive(1, 300, 0, 0);
    check("clamp high cnt", cnt[0], 235);
    check("clamp high wrapped", wrapped[1], 0);
    drive(1, -400, 0, 0);
    check("clamp low cnt", cnt[1], -230);
    check("clamp low at_limit", at_limit[0], 0);

    drive(1, -20, 0, 0);
    drive(0, 0, 1, 1);
    check("count -15", cnt[0], -15);
    drive(0, 0, 1, 1);
    check("count -10", cnt[0], -10);
    #1 rst_n = 1'b0;
    #1 check_reset_state("async reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #3;
    check("resume cnt", cnt[0], -45);
    check("resume wrap inst cnt", cnt[1], -45);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/param_step_counter.md
PARAM_STEP_COUNTER -- requirements
Module: param_step_counter

Interface
REQ-001 Parameter WIDTH, default 10: counter width in bits, two's-complement signed.
REQ-002 Parameter INIT, default -50: value loaded on reset.
REQ-003 Parameter MIN_VAL, default -230: lowest legal count.
REQ-004 Parameter MAX_VAL, default 235: highest legal count.
REQ-005 Parameter UP_STEP, default 5: increment in up mode, positive.
REQ-006 Parameter DOWN_STEP, default 9: decrement magnitude in down mode, positive.
REQ-007 Parameter UP_SKIP_VAL, default -16: count at which the up step doubles.
REQ-008 Parameter DOWN_SKIP_VAL, default -2: count at which the down step doubles.
REQ-009 Parameter WRAP, default 0: 0 holds at the bound, 1 wraps to the opposite bound.
REQ-010 clk  input  1  rising-edge clock, the only clock.
REQ-011 rst_n  input  1  reset, asynchronous, active-low.
REQ-012 en  input  1  count enable.
REQ-013 mode  input  1  direction: 1 = up, 0 = down.
REQ-014 load  input  1  synchronous load strobe.
REQ-015 load_val  input  WIDTH  signed load value.
REQ-016 cnt  output  WIDTH  signed count, registered.
REQ-017 at_limit  output  1  registered; 1 = the last enabled step was blocked at a bound.
REQ-018 skipped  output  1  registered; 1 = the last step was doubled.
REQ-019 wrapped  output  1  registered; 1 = the last step wrapped.
REQ-020 wrap_cnt  output  8  number of wraps since reset, saturating at 255.

Function
REQ-021 All arithmetic SHALL use WIDTH+2-bit signed intermediates, so no step or comparison overflows.
REQ-022 Priority SHALL be load, then en, then hold.
REQ-023 On load, cnt SHALL take load_val clamped to [MIN_VAL, MAX_VAL], and at_limit, skipped and wrapped SHALL be 0 the next cycle.
REQ-024 With en=0 and load=0, cnt SHALL hold and at_limit, skipped and wrapped SHALL be 0 the next cycle.
REQ-025 With en=1 and mode=1, step SHALL be 2*UP_STEP when cnt==UP_SKIP_VAL, otherwise UP_STEP; nxt = cnt+step.
REQ-026 With en=1 and mode=0, step SHALL be 2*DOWN_STEP when cnt==DOWN_SKIP_VAL, otherwise DOWN_STEP; nxt = cnt-step.
REQ-027 If nxt is within [MIN_VAL, MAX_VAL], cnt SHALL take nxt, and skipped SHALL be 1 only when the step was doubled.
REQ-028 If nxt is out of range and WRAP=0, cnt SHALL hold and at_limit SHALL be 1 with skipped 0.
REQ-029 If nxt is out of range and WRAP=1:
- cnt SHALL go to MIN_VAL (up) or MAX_VAL (down);
- wrapped SHALL be 1;
- wrap_cnt SHALL increment, saturating at 255.
REQ-030 All flags SHALL be mutually exclusive and SHALL describe only the most recent cycle's operation; latency from inputs to cnt and flags is one cycle.
REQ-031 A mode change SHALL take effect on the same edge, with no dead cycle.
REQ-032 Parameter legality SHALL be checked at elaboration:
- MIN_VAL <= INIT <= MAX_VAL;
- steps > 0;
- 2*step < MAX_VAL-MIN_VAL;
- all values representable in WIDTH bits.

Reset
REQ-033 rst_n=0 SHALL, immediately and without a clock edge, set cnt=INIT, at_limit=0, skipped=0, wrapped=0 and wrap_cnt=0.
REQ-034 Reset deassertion SHALL be synchronised by the integrator; the first operation occurs on the first rising edge with rst_n=1.
REQ-035 Reset asserted mid-operation SHALL override load and en in the same cycle.

Verification (default parameters unless stated)
REQ-036 load_val=-16, then en=1, mode=1 -> cnt=-6, skipped=1; next edge -> cnt=-1, skipped=0.
REQ-037 load_val=-2, then en=1, mode=0 -> cnt=-20, skipped=1.
REQ-038 load_val=233, en=1, mode=1, WRAP=0 -> cnt stays 233, at_limit=1 on every edge; load_val=-225 with mode=0 -> cnt stays -225, at_limit=1.
REQ-039 WRAP=1, load_val=233, en=1, mode=1 -> cnt=-230, wrapped=1, wrap_cnt=1; 300 forced wraps -> wrap_cnt=255.
REQ-040 load_val=300 -> cnt=235; load_val=-400 -> cnt=-230; all flags 0.
REQ-041 Counting up from -20 with rst_n pulsed low between edges -> cnt=-50 and all flags 0 before the next edge; counting resumes from -50.
